// File: rtl/mul_seq.sv
// mul_seq: sequential shift-add multiplier, one partial-product bit per clock.
// Operands are converted to magnitudes up front, multiplied unsigned, and the
// sign is reapplied on the last step, so all four signed/unsigned mixes share
// one WIDTH-bit adder. The result lands on prod only on the done cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; prod holds the last result
// RUN   | one add/shift per edge; the last step writes prod and pulses done
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               a_signed,
  input  logic               b_signed,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   ma_q, ma_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_d, done_d;
  logic [2*WIDTH-1:0] prod_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;

  // Magnitudes stay WIDTH bits wide: the most-negative value maps to
  // 2^(WIDTH-1), which still fits as an unsigned number.
  assign a_neg = a_signed & a[WIDTH-1];
  assign b_neg = b_signed & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_mag = b_neg ? (~b + WIDTH'(1)) : b;

  // The upper half plus the multiplicand needs one extra bit; that carry
  // is shifted back in at the top so nothing is lost.
  assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, ma_q} : '0);
  assign acc_step = {sum, acc_q[WIDTH-1:1]};

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ma_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      prod    <= '0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      prod    <= prod_d;
    end
  end

  // Next-state and next-output logic; done is a one-cycle pulse by default.
  always_comb begin
    state_d = state_q;
    ma_d    = ma_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy;
    done_d  = 1'b0;
    prod_d  = prod;
    case (state_q)
      IDLE: begin
        if (start) begin
          ma_d    = a_mag;
          neg_d   = a_neg ^ b_neg;
          acc_d   = {{WIDTH{1'b0}}, b_mag};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Negating a zero product yields zero, so no special case is needed.
          prod_d  = neg_q ? (~acc_step + (2*WIDTH)'(1)) : acc_step;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed checks of mul_seq at WIDTH=32 and WIDTH=8.
module tb_mul_seq;

  logic        clk;
  logic        rst32, rst8;
  logic        start32, as32, bs32, busy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] prod32;
  logic        start8, as8, bs8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  int checks   = 0;
  int failures = 0;

  mul_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst32), .start(start32), .a(a32), .b(b32),
    .a_signed(as32), .b_signed(bs32), .busy(busy32), .done(done32), .prod(prod32)
  );

  mul_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .a_signed(as8), .b_signed(bs8), .busy(busy8), .done(done8), .prod(prod8)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] cur_prod(input bit w8);
    return w8 ? {48'b0, prod8} : prod32;
  endfunction

  function automatic logic cur_busy(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction

  function automatic logic cur_done(input bit w8);
    return w8 ? done8 : done32;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic [63:0] av, input logic [63:0] bv,
                       input bit as, input bit bs, input bit st);
    if (w8) begin
      a8 = av[7:0]; b8 = bv[7:0]; as8 = as; bs8 = bs; start8 = st;
    end else begin
      a32 = av[31:0]; b32 = bv[31:0]; as32 = as; bs32 = bs; start32 = st;
    end
  endtask

  // Present operands for one edge, then scramble them so any late sampling shows up.
  task automatic start_op(input bit w8, input logic [63:0] av, input logic [63:0] bv,
                          input bit as, input bit bs);
    drive(w8, av, bv, as, bs, 1'b1);
    @(posedge clk); #1;
    drive(w8, ~av, ~bv, ~as, ~bs, 1'b0);
  endtask

  // Expect done exactly lat edges from now, with prod frozen at prev until then.
  task automatic wait_done(input bit w8, input logic [63:0] exp, input logic [63:0] prev,
                           input int lat, input string tag);
    int n;
    bit got;
    bit bad;
    n = 0; got = 1'b0; bad = 1'b0;
    while (!got && n < lat + 8) begin
      @(posedge clk); #1;
      n++;
      if (cur_done(w8)) got = 1'b1;
      else if (cur_busy(w8) !== 1'b1 || cur_prod(w8) !== prev) bad = 1'b1;
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_hold"}, {63'b0, bad}, 64'd0);
    chk({tag, "_prod"}, cur_prod(w8), exp);
    chk({tag, "_busy_clr"}, {63'b0, cur_busy(w8)}, 64'd0);
  endtask

  task automatic chk_pulse(input bit w8, input string tag);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {63'b0, cur_done(w8)}, 64'd0);
  endtask

  initial begin
    int seen;
    rst32 = 1'b1; rst8 = 1'b1;
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("rst_busy32", {63'b0, busy32}, 64'd0);
    chk("rst_done32", {63'b0, done32}, 64'd0);
    chk("rst_prod32", prod32, 64'd0);
    chk("rst_prod8", {48'b0, prod8}, 64'd0);
    @(posedge clk); #1;
    rst32 = 1'b0; rst8 = 1'b0;

    start_op(1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 1'b0);
    chk("uu_max_busy", {63'b0, busy32}, 64'd1);
    wait_done(1'b0, 64'hFFFF_FFFE_0000_0001, 64'd0, 32, "uu_max");
    chk_pulse(1'b0, "uu_max");

    start_op(1'b0, 64'hFFFF_FFFD, 64'd7, 1'b1, 1'b1);
    wait_done(1'b0, 64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFE_0000_0001, 32, "ss_m3x7");
    chk_pulse(1'b0, "ss_m3x7");

    start_op(1'b0, 64'h8000_0000, 64'h8000_0000, 1'b1, 1'b1);
    wait_done(1'b0, 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFEB, 32, "ss_minmin");
    chk_pulse(1'b0, "ss_minmin");

    start_op(1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done(1'b0, 64'hFFFF_FFFF_0000_0001, 64'h4000_0000_0000_0000, 32, "su_m1xmax");
    chk_pulse(1'b0, "su_m1xmax");

    start_op(1'b0, 64'hFFFF_FFFB, 64'd0, 1'b1, 1'b1);
    wait_done(1'b0, 64'd0, 64'hFFFF_FFFF_0000_0001, 32, "zero_neg");
    chk_pulse(1'b0, "zero_neg");

    start_op(1'b0, 64'd5, 64'hFFFF_FFFE, 1'b0, 1'b1);
    wait_done(1'b0, 64'hFFFF_FFFF_FFFF_FFF6, 64'd0, 32, "us_5xm2");
    chk_pulse(1'b0, "us_5xm2");

    // A start pulse mid-operation must not disturb the running multiply.
    start_op(1'b0, 64'd6, 64'd7, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    drive(1'b0, 64'd9, 64'd7, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 64'd9, 64'd7, 1'b0, 1'b0, 1'b0);
    chk("ign_busy", {63'b0, busy32}, 64'd1);
    wait_done(1'b0, 64'd42, 64'hFFFF_FFFF_FFFF_FFF6, 27, "ign_6x7");
    chk_pulse(1'b0, "ign_6x7");

    // Back-to-back: start asserted in the done cycle is accepted immediately.
    start_op(1'b0, 64'd16, 64'd16, 1'b0, 1'b0);
    wait_done(1'b0, 64'd256, 64'd42, 32, "b2b_first");
    drive(1'b0, 64'd2, 64'd3, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("b2b_pulse", {63'b0, done32}, 64'd0);
    chk("b2b_restart_busy", {63'b0, busy32}, 64'd1);
    wait_done(1'b0, 64'd6, 64'd256, 32, "b2b_second");
    chk_pulse(1'b0, "b2b_second");

    // Asynchronous reset in the middle of an operation.
    start_op(1'b0, 64'hFFFF_FFFF, 64'd3, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #3;
    rst32 = 1'b1;
    #1;
    chk("arst_busy", {63'b0, busy32}, 64'd0);
    chk("arst_done", {63'b0, done32}, 64'd0);
    chk("arst_prod", prod32, 64'd0);
    @(posedge clk); #1;
    rst32 = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done32 || busy32) seen = 1;
    end
    chk("arst_no_done", 64'(seen), 64'd0);
    start_op(1'b0, 64'd5, 64'd5, 1'b0, 1'b0);
    wait_done(1'b0, 64'd25, 64'd0, 32, "arst_5x5");
    chk_pulse(1'b0, "arst_5x5");

    // WIDTH=8 instance.
    start_op(1'b1, 64'h80, 64'h80, 1'b1, 1'b1);
    chk("w8_busy", {63'b0, busy8}, 64'd1);
    wait_done(1'b1, 64'h4000, 64'd0, 8, "w8_minmin");
    chk_pulse(1'b1, "w8_minmin");

    start_op(1'b1, 64'hFF, 64'hFF, 1'b0, 1'b0);
    wait_done(1'b1, 64'hFE01, 64'h4000, 8, "w8_uu_max");
    chk_pulse(1'b1, "w8_uu_max");

    start_op(1'b1, 64'h80, 64'hFF, 1'b1, 1'b0);
    wait_done(1'b1, 64'h8080, 64'hFE01, 8, "w8_su");
    chk_pulse(1'b1, "w8_su");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Parametrised, multi-cycle shift-add multiplier; successor to the combinational 32x32 unsigned multiplier.
- Computes one partial product bit per clock, so the area cost is one WIDTH-bit adder rather than a WIDTH-deep adder chain.
- Each operand can be treated as signed or unsigned independently, which covers MUL/MULH/MULHSU/MULHU.
- Sits beside the ALU in the execute stage and uses a start/busy/done handshake that the pipeline stalls on.

Parameters:
- WIDTH, 32, operand width in bits (legal range 2..64); the product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply; sampled only while idle (busy=0).
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- a_signed  input  1  1 = a is two's complement; 0 = unsigned.
- b_signed  input  1  1 = b is two's complement; 0 = unsigned.
- busy  output  1  operation in progress; new starts are ignored.
- done  output  1  single-cycle pulse; prod is valid from this cycle.
- prod  output  2*WIDTH  registered product; holds its value until the next done.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, busy=0, done=0, prod=0; counter and internal registers cleared.
  - Any in-flight operation is discarded; no done is produced for it.
- States: IDLE and RUN. All outputs are registered.
- IDLE:
  - done defaults to 0 on each edge unless the final RUN step sets it.
  - On an edge with start=1:
    - latch ma=|a| if (a_signed and a[MSB]), else a; likewise mb from b;
    - latch neg = (a_signed & a[MSB]) ^ (b_signed & b[MSB]);
    - acc = {WIDTH zeros, mb}; cnt=0; busy<=1; state<=RUN.
  - Magnitudes are WIDTH-bit unsigned, so the most-negative value (2^(WIDTH-1)) is represented exactly.
- RUN, on each edge:
  - if acc[0], acc[2W-1:W] += ma, computed with a W+1-bit sum so the carry is kept;
  - then shift acc right by 1, taking the carry in at the MSB;
  - cnt increments.
- Final RUN step: on the edge that processes bit WIDTH-1:
  - prod <= neg ? (two's-complement negation of the final acc) : final acc;
  - done<=1, busy<=0, state<=IDLE.
- Latency:
  - Start sampled at edge E0 means done and a valid prod appear at edge E_WIDTH (32 clocks for WIDTH=32). Latency does not depend on the data.
  - done is high for exactly one cycle.
- Back-to-back: start=1 during the done cycle is accepted, because the block is already in IDLE. Maximum throughput is one result per WIDTH cycles.
- start=1 while busy: ignored. Changes to a, b or the mode bits while busy have no effect on the current result.
- Zero operand combined with neg=1: the result is 0, since negating 0 gives 0.
- prod is never updated except on done (or by reset). Partial results never appear on prod.
- Width rules:
  - Unsigned x unsigned gives an exact 2*WIDTH-bit product.
  - Any signed combination gives an exact 2*WIDTH-bit two's-complement product; no overflow is possible.

Test Plan:
- WIDTH=32, a=b=0xFFFFFFFF, both unsigned, start at E0 -> done only at E32, prod=0xFFFFFFFE00000001; busy high from E0 to E32.
- Signed x signed: a=0xFFFFFFFD (-3), b=7 -> prod=0xFFFFFFFFFFFFFFEB (-21). Also a=b=0x80000000 signed -> prod=0x4000000000000000.
- MULHSU mode: a=0xFFFFFFFF with a_signed=1, b=0xFFFFFFFF with b_signed=0 -> prod=0xFFFFFFFF00000001. Also a=0xFFFFFFFB signed, b=0 -> prod=0.
- Handshake:
  - start with 6x7, then start pulsed with a=9 at cycle 5 -> ignored, prod=42.
  - start held high during the done cycle with 2x3 -> second done exactly 32 cycles later, prod=6.
- Reset asserted asynchronously at cycle 10 of an operation -> busy, done and prod go to 0 immediately and no done follows. A fresh start of 5x5 then gives prod=25 at the expected latency.
- WIDTH=8 instance: a=b=0x80 both signed -> prod=0x4000 with done 8 cycles after start. Unsigned 0xFF x 0xFF -> 0xFE01.
